// File: rtl/rnd_round_stage_pkg.sv
// Shared widths, constants and rounding-mode encoding for the rounding stage.
// Also holds the round-increment decision so every stage uses one definition.
package rnd_round_stage_pkg;

  localparam int MAN_W = 24;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } rnd_mode_e;

  // Round-up decision from mode, sign, significand LSB and {G,R,S}.
  function automatic logic calc_inc(input rnd_mode_e mode, input logic sign,
                                    input logic lsb, input logic [2:0] grs);
    logic inc;
    case (mode)
      RNE:     inc = grs[2] & (grs[1] | grs[0] | lsb);
      RTZ:     inc = 1'b0;
      RUP:     inc = ~sign & (|grs);
      RDN:     inc = sign & (|grs);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/rnd_round_stage_add.sv
// Significand incrementer: adds a single carry-in bit and exposes the carry-out
// as the top bit of the sum.
module RND_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_data,
  input  logic         i_carry,
  output logic [W:0]   o_sum
);

  assign o_sum = {1'b0, i_data} + {{W{1'b0}}, i_carry};

endmodule

// File: rtl/rnd_round_stage.sv
// Two-stage IEEE-style rounding stage: S1 captures the operand and decides the
// increment, S2 applies it and resolves carry-out, subnormal promotion and overflow.
module rnd_round_stage
  import rnd_round_stage_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  input  logic [2:0]       i_grs,
  input  logic [1:0]       i_rnd_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W-2:0] o_man,
  output logic             o_inexact,
  output logic             o_overflow
);

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MAN_W-1:0] r_s1_man;
  logic             r_s1_inc;
  logic             r_s1_inexact;
  logic             r_s1_special;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_in_special;
  logic             w_in_inc;
  logic [MAN_W:0]   w_sum;
  logic [EXP_W-1:0] w_exp_inc;
  logic [EXP_W-1:0] w_s2_exp;
  logic [MAN_W-2:0] w_s2_man;
  logic             w_s2_ovf;

  assign w_s2_load = ~o_valid | i_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign o_ready   = ~i_rst & w_s1_load;

  // Inf/NaN operands bypass rounding entirely.
  assign w_in_special = (i_exp == EXP_MAX);
  assign w_in_inc     = w_in_special ? 1'b0
                      : calc_inc(rnd_mode_e'(i_rnd_mode), i_sign, i_man[0], i_grs);

  // S1: capture operand and increment decision
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_man     <= '0;
      r_s1_inc     <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_special <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid   <= i_valid;
      r_s1_sign    <= i_sign;
      r_s1_exp     <= i_exp;
      r_s1_man     <= i_man;
      r_s1_inc     <= w_in_inc;
      r_s1_inexact <= ~w_in_special & (|i_grs);
      r_s1_special <= w_in_special;
    end else begin
      r_s1_valid   <= r_s1_valid;
    end
  end

  RND_add #(.W(MAN_W)) u_add (
    .i_data  (r_s1_man),
    .i_carry (r_s1_inc),
    .o_sum   (w_sum)
  );

  assign w_exp_inc = r_s1_exp + {{(EXP_W-1){1'b0}}, 1'b1};

  // S2 result: carry-out, subnormal promotion and overflow resolution
  always_comb begin
    w_s2_exp = r_s1_exp;
    w_s2_man = w_sum[MAN_W-2:0];
    w_s2_ovf = 1'b0;
    if (r_s1_special) begin
      w_s2_man = r_s1_man[MAN_W-2:0];
    end else if (w_sum[MAN_W]) begin
      w_s2_exp = w_exp_inc;
      w_s2_man = '0;
      w_s2_ovf = (w_exp_inc == EXP_MAX);
    end else if ((r_s1_exp == '0) && w_sum[MAN_W-1]) begin
      w_s2_exp = {{(EXP_W-1){1'b0}}, 1'b1};
    end else begin
      w_s2_exp = r_s1_exp;
    end
  end

  // S2: registered outputs, held while downstream stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_sign     <= 1'b0;
      o_exp      <= '0;
      o_man      <= '0;
      o_inexact  <= 1'b0;
      o_overflow <= 1'b0;
    end else if (w_s2_load) begin
      o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        o_sign     <= r_s1_sign;
        o_exp      <= w_s2_exp;
        o_man      <= w_s2_man;
        o_inexact  <= r_s1_inexact;
        o_overflow <= w_s2_ovf;
      end else begin
        o_sign     <= o_sign;
      end
    end else begin
      o_valid <= o_valid;
    end
  end

endmodule

// File: tb/tb_rnd_round_stage.sv
// Directed, table-driven bench for rnd_round_stage with hand-computed expectations,
// plus backpressure and mid-flight reset sequences.
module tb_rnd_round_stage;
  import rnd_round_stage_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_sign, i_ready;
  logic [7:0]  i_exp;
  logic [23:0] i_man;
  logic [2:0]  i_grs;
  logic [1:0]  i_rnd_mode;
  logic        o_ready, o_valid, o_sign, o_inexact, o_overflow;
  logic [7:0]  o_exp;
  logic [22:0] o_man;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic [2:0]  grs;
    logic [1:0]  mode;
    logic [33:0] res;   // {sign, exp, man[22:0], inexact, overflow}
  } vec_t;

  vec_t vecs [16];

  rnd_round_stage dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .i_grs(i_grs),
    .i_rnd_mode(i_rnd_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_man(o_man), .o_inexact(o_inexact),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] cur_out();
    return {o_sign, o_exp, o_man, o_inexact, o_overflow};
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    i_sign = v.sign; i_exp = v.exp; i_man = v.man; i_grs = v.grs; i_rnd_mode = v.mode;
  endtask

  initial begin
    logic [33:0] q [$];
    logic [33:0] held;
    logic        was_stalled;
    logic        saw_valid;
    int          idx, got, cyc;

    vecs[0]  = '{1'b0, 8'h80, 24'h800001, 3'b100, RNE, {1'b0, 8'h80, 23'h000002, 1'b1, 1'b0}};
    vecs[1]  = '{1'b0, 8'h80, 24'h800002, 3'b100, RNE, {1'b0, 8'h80, 23'h000002, 1'b1, 1'b0}};
    vecs[2]  = '{1'b0, 8'h7F, 24'hFFFFFF, 3'b110, RNE, {1'b0, 8'h80, 23'h000000, 1'b1, 1'b0}};
    vecs[3]  = '{1'b0, 8'hFE, 24'hFFFFFF, 3'b111, RUP, {1'b0, 8'hFF, 23'h000000, 1'b1, 1'b1}};
    vecs[4]  = '{1'b0, 8'hFE, 24'hFFFFFF, 3'b111, RTZ, {1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0}};
    vecs[5]  = '{1'b0, 8'h00, 24'h7FFFFF, 3'b100, RNE, {1'b0, 8'h01, 23'h000000, 1'b1, 1'b0}};
    vecs[6]  = '{1'b1, 8'h10, 24'h800000, 3'b001, RDN, {1'b1, 8'h10, 23'h000001, 1'b1, 1'b0}};
    vecs[7]  = '{1'b0, 8'h10, 24'h800000, 3'b001, RDN, {1'b0, 8'h10, 23'h000000, 1'b1, 1'b0}};
    vecs[8]  = '{1'b1, 8'h10, 24'h800000, 3'b011, RUP, {1'b1, 8'h10, 23'h000000, 1'b1, 1'b0}};
    vecs[9]  = '{1'b0, 8'h10, 24'h800000, 3'b110, RNE, {1'b0, 8'h10, 23'h000001, 1'b1, 1'b0}};
    vecs[10] = '{1'b0, 8'h10, 24'h800001, 3'b011, RNE, {1'b0, 8'h10, 23'h000001, 1'b1, 1'b0}};
    vecs[11] = '{1'b1, 8'h20, 24'hABCDEF, 3'b000, RNE, {1'b1, 8'h20, 23'h2BCDEF, 1'b0, 1'b0}};
    vecs[12] = '{1'b0, 8'hFF, 24'h800000, 3'b111, RUP, {1'b0, 8'hFF, 23'h000000, 1'b0, 1'b0}};
    vecs[13] = '{1'b1, 8'hFF, 24'hC00001, 3'b111, RNE, {1'b1, 8'hFF, 23'h400001, 1'b0, 1'b0}};
    vecs[14] = '{1'b1, 8'hFE, 24'hFFFFFF, 3'b101, RDN, {1'b1, 8'hFF, 23'h000000, 1'b1, 1'b1}};
    vecs[15] = '{1'b0, 8'h00, 24'h000001, 3'b111, RUP, {1'b0, 8'h00, 23'h000002, 1'b1, 1'b0}};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset_ready", {33'd0, o_ready}, 34'd0);
    check("reset_valid", {33'd0, o_valid}, 34'd0);
    check("reset_outputs", cur_out(), 34'd0);
    i_rst = 1'b0;
    #1;
    check("ready_after_reset", {33'd0, o_ready}, 34'd1);

    // Single-operand vectors: latency 2 and result
    for (int k = 0; k < 16; k++) begin
      drive(vecs[k]);
      i_valid = 1'b1;
      check($sformatf("v%0d_ready", k), {33'd0, o_ready}, 34'd1);
      @(negedge clk);
      i_valid = 1'b0;
      check($sformatf("v%0d_lat1", k), {33'd0, o_valid}, 34'd0);
      @(negedge clk);
      check($sformatf("v%0d_lat2", k), {33'd0, o_valid}, 34'd1);
      check($sformatf("v%0d_result", k), cur_out(), vecs[k].res);
      @(negedge clk);
    end

    // Backpressure: 4 back-to-back inputs, downstream stalls 3 cycles
    idx = 0; got = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while ((got < 4) && (cyc < 40)) begin
      i_ready = !((cyc >= 2) && (cyc <= 4));
      #1;
      if (was_stalled) check($sformatf("bp_stable_c%0d", cyc), cur_out(), held);
      if (cyc == 3) check("bp_ready_low_full", {33'd0, o_ready}, 34'd0);
      if (o_valid && i_ready) begin
        check($sformatf("bp_result%0d", got), cur_out(), (q.size() > 0) ? q.pop_front() : 34'h3FFFFFFFF);
        got++;
      end
      was_stalled = o_valid && !i_ready;
      held = cur_out();
      if (idx < 4) begin
        drive(vecs[idx]);
        i_valid = 1'b1;
        if (o_ready) begin
          q.push_back(vecs[idx].res);
          idx++;
        end
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    check("bp_count", 34'(got), 34'd4);
    repeat (3) @(negedge clk);
    check("bp_no_duplicate", {33'd0, o_valid}, 34'd0);

    // Reset with two operands in flight
    drive(vecs[2]); i_valid = 1'b1;
    @(negedge clk);
    drive(vecs[3]);
    @(negedge clk);
    i_valid = 1'b0; i_rst = 1'b1;
    #1;
    check("rst_mid_ready_low", {33'd0, o_ready}, 34'd0);
    @(negedge clk);
    i_rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (o_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    check("rst_mid_no_output", {33'd0, saw_valid}, 34'd0);
    drive(vecs[9]); i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check("rst_mid_lat1", {33'd0, o_valid}, 34'd0);
    @(negedge clk);
    check("rst_mid_lat2", {33'd0, o_valid}, 34'd1);
    check("rst_mid_result", cur_out(), vecs[9].res);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rnd_round_stage.md
RND_ROUND_STAGE -- requirements
Module: rnd_round_stage

Interface
REQ-001 Parameters: MAN_W, 24, significand width including hidden bit; EXP_W, 8, biased exponent width; EXP_MAX, 255, all-ones exponent.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_valid  in  1  upstream operand valid.
REQ-005 o_ready  out  1  block accepts operand this cycle.
REQ-006 i_sign  in  1  result sign.
REQ-007 i_exp  in  EXP_W  unrounded biased exponent.
REQ-008 i_man  in  MAN_W  unrounded significand; bit 23 is hidden bit, 0 only when i_exp==0.
REQ-009 i_grs  in  3  guard, round, sticky bits ({G,R,S}, G in bit 2).
REQ-010 i_rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-011 o_valid  out  1  result valid.
REQ-012 i_ready  in  1  downstream accepts result.
REQ-013 o_sign/o_exp/o_man  out  1/EXP_W/MAN_W-1  rounded result; o_man is 23-bit fraction.
REQ-014 o_inexact  out  1  G|R|S was nonzero.
REQ-015 o_overflow  out  1  rounding carried exponent to EXP_MAX.

Function
REQ-016 Two-stage pipeline: S1 registers operand plus round-increment bit inc; S2 registers incremented result; latency exactly 2 cycles from accepted input to o_valid with no stall.
REQ-017 Transfer occurs when i_valid&o_ready (input) or o_valid&i_ready (output); throughput one per cycle when i_ready held high.
REQ-018 Stage advances when its successor is empty or draining: S2 loads when !s2_valid|i_ready; S1 loads when !s1_valid|S2 loads; o_ready = !s1_valid|S2 loads.
REQ-019 While o_valid&!i_ready, all S2 outputs stay stable.
REQ-020 inc: RNE = G&(R|S|man[0]); RTZ = 0; RUP = !sign&(G|R|S); RDN = sign&(G|R|S).
REQ-021 o_inexact = G|R|S, independent of inc.
REQ-022 Rounded significand = i_man + inc, 25-bit with carry-out c.
REQ-023 c=1: o_man = 0, exponent = i_exp+1.
REQ-024 i_exp==0, sum bit 23 becomes 1 without c (subnormal rounds to normal): o_exp = 1.
REQ-025 Resulting exponent == EXP_MAX from rounding: o_exp=EXP_MAX, o_man=0, o_overflow=1.
REQ-026 i_exp==EXP_MAX on input (inf/NaN): passed through unchanged, inc forced 0, o_inexact=0, o_overflow=0.
REQ-027 o_sign = i_sign always; rounding never changes sign.

Reset
REQ-028 i_rst high at a clock edge clears s1_valid, s2_valid, o_valid, o_exp, o_man, o_sign, o_inexact, o_overflow to 0.
REQ-029 Reset mid-operation discards all in-flight operands; no output after reset until a new accepted input.
REQ-030 During reset o_ready is 0; first acceptance is the first edge after i_rst deasserts.

Structure
REQ-031 Shared package holds MAN_W, EXP_W, EXP_MAX and enum rnd_mode_e (RNE, RTZ, RUP, RDN).
REQ-032 S2 increment uses one instance of existing sub-module RND_add (i_data=i_man, i_carry=inc); no second adder.

Verification
REQ-033 RNE tie-even: man=0x800001, grs=100 -> o_man=0x000002, o_inexact=1; man=0x800002, grs=100 -> o_man=0x000002.
REQ-034 Carry-out: exp=0x7F, man=0xFFFFFF, grs=110, RNE -> o_exp=0x80, o_man=0, 2 cycles later.
REQ-035 Overflow: exp=0xFE, man=0xFFFFFF, grs=111, RUP, sign=0 -> o_exp=0xFF, o_man=0, o_overflow=1; same with RTZ -> o_exp=0xFE, o_man=0x7FFFFF.
REQ-036 Subnormal promote: exp=0, man=0x7FFFFF, grs=100, RNE -> o_exp=1, o_man=0.
REQ-037 Backpressure: 4 back-to-back inputs, i_ready low 3 cycles after first o_valid -> o_ready low once pipeline full, outputs stable, all 4 results in order, none lost or duplicated.
REQ-038 Reset mid-flight: accept 2 operands, assert i_rst 1 cycle -> o_valid stays 0 until next accepted input plus 2 cycles.
